axi4_read_burst_splitter: RTL

AXI4_READ_BURST_SPLITTER -- requirements
Module: axi4_read_burst_splitter

---
 rtl/axi4_read_burst_splitter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/axi4_read_burst_splitter.sv
// rtl/axi4_read_burst_splitter.sv - splits AXI4 read bursts into single-beat reads and reassembles R
module axi4_read_burst_splitter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  io_s_axi_ar_valid,
    output logic                  io_s_axi_ar_ready,
    input  logic [ID_WIDTH-1:0]   io_s_axi_ar_bits_id,
    input  logic [ADDR_WIDTH-1:0] io_s_axi_ar_bits_addr,
    input  logic [3:0]            io_s_axi_ar_bits_len,
    input  logic [2:0]            io_s_axi_ar_bits_size,
    input  logic [1:0]            io_s_axi_ar_bits_burst,
    output logic                  io_s_axi_r_valid,
    input  logic                  io_s_axi_r_ready,
    output logic [ID_WIDTH-1:0]   io_s_axi_r_bits_id,
    output logic [DATA_WIDTH-1:0] io_s_axi_r_bits_data,
    output logic [1:0]            io_s_axi_r_bits_resp,
    output logic                  io_s_axi_r_bits_last,
    output logic                  io_m_axi_ar_valid,
    input  logic                  io_m_axi_ar_ready,
    output logic [ID_WIDTH-1:0]   io_m_axi_ar_bits_id,
    output logic [ADDR_WIDTH-1:0] io_m_axi_ar_bits_addr,
    output logic [3:0]            io_m_axi_ar_bits_len,
    output logic [2:0]            io_m_axi_ar_bits_size,
    output logic [1:0]            io_m_axi_ar_bits_burst,
    input  logic                  io_m_axi_r_valid,
    output logic                  io_m_axi_r_ready,
    input  logic [DATA_WIDTH-1:0] io_m_axi_r_bits_data,
    input  logic [1:0]            io_m_axi_r_bits_resp
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_R} state_t;

    localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

    state_t                state, state_nxt;
    logic [ID_WIDTH-1:0]   id_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [3:0]            len_q;
    logic [2:0]            size_q;
    logic [1:0]            burst_q;
    logic [3:0]            beat_q;

    logic                  ar_hs, r_hs, last_beat;
    logic [ADDR_WIDTH-1:0] step, wrap_mask, addr_nxt;

    assign ar_hs     = io_s_axi_ar_valid && io_s_axi_ar_ready;
    assign r_hs      = io_s_axi_r_valid && io_s_axi_r_ready;
    assign last_beat = (beat_q == len_q);

    // WRAP keeps the upper bits of the aligned window and lets only the low bits roll over.
    assign step      = ONE << size_q;
    assign wrap_mask = ((ADDR_WIDTH'(len_q) + ONE) << size_q) - ONE;

    always_comb begin
        addr_nxt = addr_q + step;
        case (burst_q)
            2'b00:   addr_nxt = addr_q;
            2'b10:   addr_nxt = (addr_q & ~wrap_mask) | ((addr_q + step) & wrap_mask);
            default: addr_nxt = addr_q + step;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            size_q  <= '0;
            burst_q <= '0;
            beat_q  <= '0;
        end else begin
            state <= state_nxt;
            if (ar_hs) begin
                id_q    <= io_s_axi_ar_bits_id;
                addr_q  <= io_s_axi_ar_bits_addr;
                len_q   <= io_s_axi_ar_bits_len;
                size_q  <= io_s_axi_ar_bits_size;
                burst_q <= io_s_axi_ar_bits_burst;
                beat_q  <= '0;
            end else if (r_hs && !last_beat) begin
                beat_q <= beat_q + 4'd1;
                addr_q <= addr_nxt;
            end
        end
    end

    always_comb begin
        state_nxt            = state;
        io_s_axi_ar_ready    = 1'b0;
        io_m_axi_ar_valid    = 1'b0;
        io_s_axi_r_valid     = 1'b0;
        io_m_axi_r_ready     = 1'b0;
        io_s_axi_r_bits_last = 1'b0;
        case (state)
            IDLE: begin
                io_s_axi_ar_ready = reset;
                if (io_s_axi_ar_valid && reset) state_nxt = ISSUE;
            end
            ISSUE: begin
                io_m_axi_ar_valid = 1'b1;
                if (io_m_axi_ar_ready) state_nxt = WAIT_R;
            end
            WAIT_R: begin
                io_s_axi_r_valid     = io_m_axi_r_valid;
                io_m_axi_r_ready     = io_s_axi_r_ready;
                io_s_axi_r_bits_last = last_beat;
                if (io_m_axi_r_valid && io_s_axi_r_ready) state_nxt = last_beat ? IDLE : ISSUE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign io_m_axi_ar_bits_id    = id_q;
    assign io_m_axi_ar_bits_addr  = addr_q;
    assign io_m_axi_ar_bits_len   = 4'd0;
    assign io_m_axi_ar_bits_size  = size_q;
    assign io_m_axi_ar_bits_burst = 2'b01;
    assign io_s_axi_r_bits_id     = id_q;
    assign io_s_axi_r_bits_data   = io_m_axi_r_bits_data;
    assign io_s_axi_r_bits_resp   = io_m_axi_r_bits_resp;

endmodule
